block_check_arbiter: RTL and testbench
======================================

Name: block_check_arbiter

Overview:
- Shares one keyword-nesting checker ("begin"/"end" balance over an 8-bit ASCII stream) between two character-stream requesters.
- Grants one requester a whole sentence at a time, using round-robin priority, and clears the checker before each sentence.
- Forwards the sentence's characters to the checker, flushes the final word, samples the checker verdict and returns it to the granted requester with a done pulse.
- Sits between the text-source front ends and the checker instance.

Parameters:
- MAX_LEN, 255: maximum non-terminator characters per sentence; exceeding it sets overflow.
- TERM, 8'h2E: sentence terminator character ('.'). It is never forwarded to the checker.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- s_valid  in  2  per-requester character valid.
- s_data0  in  8  requester 0 character.
- s_data1  in  8  requester 1 character.
- s_ready  out  2  per-requester accept; a character transfers when s_valid[i] & s_ready[i].
- gnt  out  2  one-hot current owner; 0 when idle.
- busy  out  1  1 in any state other than IDLE.
- done  out  2  one-cycle pulse to the owner when its verdict is ready.
- result  out  1  verdict, valid while done != 0: 1 = balanced and legal, 0 = illegal.
- ovf  out  1  valid with done: 1 = sentence exceeded MAX_LEN.
- chk_clr  out  1  registered, active-high one-cycle clear to the checker.
- chk_valid  out  1  registered; the checker advances only on cycles where chk_valid=1.
- chk_data  out  8  registered character to the checker.
- chk_result  in  1  checker combinational verdict for the characters consumed so far.

Behaviour:
- Reset (reset=0 at posedge):
  - state=IDLE; gnt=0, s_ready=0, done=0, result=0, ovf=0, chk_clr=0, chk_valid=0, chk_data=0.
  - Length counter=0; last_grant=1, so requester 0 wins first.
  - Reset mid-sentence abandons the sentence with no done pulse.
- States and transitions:
  - IDLE: if any s_valid bit is high, grant one requester. If both are high, grant the one != last_grant; otherwise grant the sole requester. Set gnt, go to CLEAR. No character is consumed in IDLE.
  - CLEAR (1 cycle): chk_clr=1 in the following cycle (registered). Counter=0, ovf flag=0. Go to STREAM.
  - STREAM:
    - s_ready[g]=1 for the owner only; s_ready=0 for the other requester.
    - Non-TERM character accepted at cycle t: if counter < MAX_LEN, chk_valid=1 and chk_data=char during t+1, and counter increments.
    - Otherwise (counter = MAX_LEN): set the ovf flag, do not forward, and do not increment past MAX_LEN.
    - Cycle with no transfer: chk_valid=0 next cycle. The checker holds state, so requester stalls are harmless.
    - TERM accepted: go to FLUSH.
  - FLUSH (1 cycle): chk_valid=1, chk_data=8'h20. The space commits any pending keyword. s_ready=0.
  - SAMPLE (1 cycle): capture result = chk_result & ~ovf_flag, and ovf = ovf_flag.
  - RESP (1 cycle): done[g]=1; result and ovf stable; last_grant=g. Next cycle: gnt=0, go to IDLE.
- Latency: TERM accepted at cycle t → space on chk_* at t+1 → sample at t+2 → done at t+3.
- Back-to-back operation:
  - Minimum turnaround from done to the next grant is 1 cycle (IDLE).
  - A requester holding s_valid through RESP competes normally in IDLE.
- Empty sentence (first character is TERM): checker sees only the clear and one space; result=1, ovf=0.
- Owner deasserting s_valid mid-sentence: the controller waits in STREAM indefinitely. There is no timeout.
- result and ovf hold their last values until the next SAMPLE.
- chk_clr, chk_valid and chk_data are never asserted outside the cycles stated above.

Test Plan:
- Reset then requester 0 sends "begin end." → gnt=01. chk_clr one cycle, then chk_data "b","e","g","i","n"," ","e","n","d"," " with chk_valid; done=01 exactly 3 cycles after the '.' transfer; result=1, ovf=0.
- Both s_valid high from reset, each sending "end." → requester 0 first (result=0), then requester 1 (result=0); gnt alternates 01 then 10.
- Requester 1 sends "begin." with s_valid toggling every other cycle → chk_valid only on transfer cycles; no chk_data duplicated; done=10, result=0.
- MAX_LEN=4, requester 0 sends "abcdef." → exactly 4 chk_valid characters plus the flush space; done=01, ovf=1, result=0.
- reset driven low mid-STREAM, then released, then requester 1 sends "." → no done for the aborted sentence; requester 1 receives done=10, result=1.

Source files
------------

// File: rtl/block_check_arbiter_if.sv
// Requester-side and checker-side signals of the shared keyword-nesting checker arbiter.
// The arbiter uses the slave modport; the text sources and checker sit on the master side.
interface block_check_arbiter_if;
    logic [1:0] s_valid;
    logic [7:0] s_data0;
    logic [7:0] s_data1;
    logic [1:0] s_ready;
    logic [1:0] gnt;
    logic       busy;
    logic [1:0] done;
    logic       result;
    logic       ovf;
    logic       chk_clr;
    logic       chk_valid;
    logic [7:0] chk_data;
    logic       chk_result;

    modport slave (
        input  s_valid, s_data0, s_data1, chk_result,
        output s_ready, gnt, busy, done, result, ovf, chk_clr, chk_valid, chk_data
    );

    modport master (
        output s_valid, s_data0, s_data1, chk_result,
        input  s_ready, gnt, busy, done, result, ovf, chk_clr, chk_valid, chk_data
    );
endinterface

// File: rtl/block_check_arbiter.sv
// Round-robin arbiter granting one requester a whole sentence on a shared begin/end checker,
// forwarding its characters, flushing the last word and returning the sampled verdict.
module block_check_arbiter #(
    parameter int         MAX_LEN = 255,
    parameter logic [7:0] TERM    = 8'h2E
) (
    input  logic                 clk,
    input  logic                 reset,
    block_check_arbiter_if.slave bus
);
    localparam int            CW        = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] LEN_LIMIT = CW'(MAX_LEN);

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, FLUSH, SAMPLE, RESP} state_t;

    state_t        state;
    logic          owner;
    logic          last_grant;
    logic          ovf_flag;
    logic [CW-1:0] count;
    logic [1:0]    gnt_q;
    logic [1:0]    s_ready_q;
    logic [1:0]    done_q;
    logic          result_q;
    logic          ovf_q;
    logic          chk_clr_q;
    logic          chk_valid_q;
    logic [7:0]    chk_data_q;

    logic          pick;
    logic          take;
    logic [7:0]    owner_data;

    // On a tie the requester that did not hold the checker last wins.
    assign pick       = (bus.s_valid == 2'b11) ? ~last_grant : bus.s_valid[1];
    assign take       = (bus.s_valid & s_ready_q) != 2'b00;
    assign owner_data = owner ? bus.s_data1 : bus.s_data0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            ovf_flag    <= 1'b0;
            count       <= '0;
            gnt_q       <= 2'b00;
            s_ready_q   <= 2'b00;
            done_q      <= 2'b00;
            result_q    <= 1'b0;
            ovf_q       <= 1'b0;
            chk_clr_q   <= 1'b0;
            chk_valid_q <= 1'b0;
            chk_data_q  <= 8'h00;
        end else begin
            chk_clr_q   <= 1'b0;
            chk_valid_q <= 1'b0;
            chk_data_q  <= 8'h00;
            done_q      <= 2'b00;
            case (state)
                IDLE: begin
                    if (bus.s_valid != 2'b00) begin
                        owner <= pick;
                        gnt_q <= pick ? 2'b10 : 2'b01;
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    chk_clr_q <= 1'b1;
                    count     <= '0;
                    ovf_flag  <= 1'b0;
                    s_ready_q <= gnt_q;
                    state     <= STREAM;
                end
                STREAM: begin
                    // The terminator itself is replaced by a space that commits the last word.
                    if (take) begin
                        if (owner_data == TERM) begin
                            s_ready_q   <= 2'b00;
                            chk_valid_q <= 1'b1;
                            chk_data_q  <= 8'h20;
                            state       <= FLUSH;
                        end else if (count < LEN_LIMIT) begin
                            chk_valid_q <= 1'b1;
                            chk_data_q  <= owner_data;
                            count       <= count + 1'b1;
                        end else begin
                            ovf_flag <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    state <= SAMPLE;
                end
                SAMPLE: begin
                    result_q <= bus.chk_result & ~ovf_flag;
                    ovf_q    <= ovf_flag;
                    done_q   <= gnt_q;
                    state    <= RESP;
                end
                RESP: begin
                    last_grant <= owner;
                    gnt_q      <= 2'b00;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.ovf       = ovf_q;
    assign bus.chk_clr   = chk_clr_q;
    assign bus.chk_valid = chk_valid_q;
    assign bus.chk_data  = chk_data_q;
endmodule

// File: tb/tb_block_check_arbiter.sv
// Bench for block_check_arbiter: two instances (MAX_LEN 255 and 4) share one stimulus stream,
// each feeding a stand-in begin/end checker; verdicts are compared to a sentence-level model.
module tb_block_check_arbiter;
    localparam int         LEN_A = 255;
    localparam int         LEN_B = 4;
    localparam logic [7:0] TERM  = 8'h2E;

    typedef struct {
        int    req;
        string text;
        bit    toggle;
        bit    res_a;
        bit    ovf_a;
        bit    res_b;
        bit    ovf_b;
    } vec_t;

    logic clk;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;

    block_check_arbiter_if bus ();
    block_check_arbiter_if bus4 ();

    block_check_arbiter #(.MAX_LEN(LEN_A), .TERM(TERM)) dut (.clk(clk), .reset(reset), .bus(bus));
    block_check_arbiter #(.MAX_LEN(LEN_B), .TERM(TERM)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    assign bus4.s_valid = bus.s_valid;
    assign bus4.s_data0 = bus.s_data0;
    assign bus4.s_data1 = bus.s_data1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in checkers (index 0 serves dut, 1 serves dut4) plus stream/clear/done monitors.
    int         depth [2];
    bit         bad [2];
    string      word [2];
    string      fwd [2];
    int         clr_cnt [2];
    int         done_cnt [2];
    longint     done_time [2];
    logic [1:0] m_clr;
    logic [1:0] m_valid;
    logic [7:0] m_data [2];

    assign m_clr     = {bus4.chk_clr, bus.chk_clr};
    assign m_valid   = {bus4.chk_valid, bus.chk_valid};
    assign m_data[0] = bus.chk_data;
    assign m_data[1] = bus4.chk_data;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (bus.done[k]) done_cnt[k]++;
            if (m_clr[k]) begin
                depth[k] = 0;
                bad[k] = 1'b0;
                word[k] = "";
                fwd[k] = "";
                clr_cnt[k]++;
            end else if (m_valid[k]) begin
                fwd[k] = {fwd[k], $sformatf("%c", m_data[k])};
                if (m_data[k] == 8'h20) begin
                    if (word[k] == "begin") depth[k]++;
                    else if (word[k] == "end") begin
                        if (depth[k] == 0) bad[k] = 1'b1;
                        else depth[k]--;
                    end
                    word[k] = "";
                end else begin
                    word[k] = {word[k], $sformatf("%c", m_data[k])};
                end
            end
        end
    end

    assign bus.chk_result  = !bad[0] && (depth[0] == 0);
    assign bus4.chk_result = !bad[1] && (depth[1] == 0);

    function automatic bit ref_balanced(input string body);
        int    lvl = 0;
        bit    legal = 1'b1;
        string w = "";
        string padded;
        padded = {body, " "};
        for (int i = 0; i < padded.len(); i++) begin
            if (padded[i] == 8'h20) begin
                if (w == "begin") lvl++;
                else if (w == "end") begin
                    if (lvl == 0) legal = 1'b0;
                    else lvl--;
                end
                w = "";
            end else begin
                w = {w, padded.substr(i, i)};
            end
        end
        return legal && (lvl == 0);
    endfunction

    function automatic void model(input string s, input int maxl, output bit res, output bit ovf,
                                  output string stream);
        int    n;
        string kept = "";
        n   = s.len() - 1;
        ovf = (n > maxl);
        for (int i = 0; i < n && i < maxl; i++) kept = {kept, s.substr(i, i)};
        res    = !ovf && ref_balanced(kept);
        stream = {kept, " "};
    endfunction

    function automatic string clip(input string s);
        return (s.len() > 40) ? s.substr(0, 39) : s;
    endfunction

    task automatic check_output(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_text(input string name, input string act, input string exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got \"%s\" (len %0d), expected \"%s\" (len %0d)",
                     name, clip(act), act.len(), clip(exp), exp.len());
        end
    endtask

    task automatic check_reset(input string tag);
        check_output({tag, " dut"}, int'({bus.gnt, bus.s_ready, bus.busy, bus.done, bus.result,
                     bus.ovf, bus.chk_clr, bus.chk_valid, bus.chk_data}), 0);
        check_output({tag, " dut4"}, int'({bus4.gnt, bus4.s_ready, bus4.busy, bus4.done, bus4.result,
                     bus4.ovf, bus4.chk_clr, bus4.chk_valid, bus4.chk_data}), 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.s_valid = 2'b00;
        repeat (2) @(negedge clk);
        check_reset("reset state");
        reset = 1'b1;
    endtask

    // Drives one requester; stops after the terminator or after 'limit' transfers (limit >= 0).
    task automatic apply_stimulus(input int req, input string s, input bit toggle, input int limit,
                                  output bit ok);
        int i = 0;
        int guard = 0;
        int sent = 0;
        bit on = 1'b0;
        bit fin = 1'b0;
        ok = 1'b1;
        while (!fin) begin
            @(negedge clk);
            on = toggle ? !on : 1'b1;
            bus.s_valid[req] = on;
            if (req == 0) bus.s_data0 = s[i];
            else bus.s_data1 = s[i];
            if (on && bus.s_ready[req]) begin
                if (sent == 0) begin
                    check_output($sformatf("gnt r%0d", req), int'(bus.gnt), 1 << req);
                    check_output($sformatf("s_ready r%0d", req), int'(bus.s_ready), 1 << req);
                end
                sent++;
                if (s[i] == TERM) fin = 1'b1;
                else i++;
                if (limit >= 0 && sent >= limit) fin = 1'b1;
            end
            guard++;
            if (!fin && guard > 1500) begin
                n_vec++;
                n_bad++;
                $display("[TB] FAIL accept timeout r%0d: %0d of %0d chars taken", req, i, s.len());
                bus.s_valid[req] = 1'b0;
                ok = 1'b0;
                fin = 1'b1;
            end
        end
    endtask

    task automatic run_sentence(input int req, input string s, input bit toggle, input bit res_a,
                                input bit ovf_a, input bit res_b, input bit ovf_b, input bit solo);
        bit    m_res;
        bit    m_ovf;
        bit    ok;
        string stream_a;
        string stream_b;
        int    clr_before;
        int    lat = 0;
        model(s, LEN_A, m_res, m_ovf, stream_a);
        model(s, LEN_B, m_res, m_ovf, stream_b);
        clr_before = clr_cnt[0];
        apply_stimulus(req, s, toggle, -1, ok);
        if (!ok) return;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) bus.s_valid[req] = 1'b0;
        end while (bus.done == 2'b00 && lat < 12);
        done_time[req] = $time;
        check_output($sformatf("latency r%0d", req), lat, 3);
        check_output($sformatf("done r%0d", req), int'(bus.done), 1 << req);
        check_output($sformatf("result \"%s\"", clip(s)), int'(bus.result), int'(res_a));
        check_output($sformatf("ovf \"%s\"", clip(s)), int'(bus.ovf), int'(ovf_a));
        check_output($sformatf("done4 r%0d", req), int'(bus4.done), 1 << req);
        check_output($sformatf("result4 \"%s\"", clip(s)), int'(bus4.result), int'(res_b));
        check_output($sformatf("ovf4 \"%s\"", clip(s)), int'(bus4.ovf), int'(ovf_b));
        check_text("stream", fwd[0], stream_a);
        check_text("stream4", fwd[1], stream_b);
        if (solo) check_output("clear pulses", clr_cnt[0] - clr_before, 1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    vec_t  tbl [$];
    string pool [5] = '{"begin", "end", "begin", "end", "ab"};
    string s;
    string tmp;
    bit    ra, oa, rb, ob, ok;
    int    nw;
    int    done0_before;

    initial begin
        reset = 1'b0;
        bus.s_valid = 2'b00;
        bus.s_data0 = 8'h00;
        bus.s_data1 = 8'h00;
        $display("[TB] starting block_check_arbiter bench");
        repeat (3) @(negedge clk);
        check_reset("initial reset");
        reset = 1'b1;

        tbl.push_back('{0, "begin end.", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1, "end.", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{0, ".", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1, "abcd.", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{0, "abcde.", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1, "begin.", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1, "begin begin end end.", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{0, "end begin.", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{0, "beginend.", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{0, "begin  end.", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        tmp = "";
        for (int i = 0; i < 255; i++) tmp = {tmp, "a"};
        tbl.push_back('{0, {tmp, "."}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1, {tmp, "a."}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});

        foreach (tbl[i])
            run_sentence(tbl[i].req, tbl[i].text, tbl[i].toggle, tbl[i].res_a, tbl[i].ovf_a,
                         tbl[i].res_b, tbl[i].ovf_b, 1'b1);

        // Both requesters waiting from reset: requester 0 is served first, then requester 1.
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) apply_reset();
            fork
                run_sentence(0, "end.", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                run_sentence(1, "end.", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            join
            check_output($sformatf("round-robin order pass %0d", pass),
                         int'(done_time[0] < done_time[1]), 1);
        end

        // Reset in the middle of a sentence abandons it without a done pulse.
        apply_stimulus(0, "begin end.", 1'b0, 3, ok);
        done0_before = done_cnt[0];
        @(negedge clk);
        check_output("busy mid-sentence", int'(bus.busy), 1);
        reset = 1'b0;
        bus.s_valid = 2'b00;
        repeat (2) @(negedge clk);
        check_reset("mid-sentence reset");
        reset = 1'b1;
        run_sentence(1, ".", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check_output("no done for aborted sentence", done_cnt[0], done0_before);

        for (int r = 0; r < 40; r++) begin
            s = "";
            nw = $urandom_range(0, 5);
            for (int w = 0; w < nw; w++) begin
                if (w > 0) s = {s, " "};
                if (w > 0 && $urandom_range(0, 7) == 0) s = {s, " "};
                s = {s, pool[$urandom_range(0, 4)]};
            end
            s = {s, "."};
            model(s, LEN_A, ra, oa, tmp);
            model(s, LEN_B, rb, ob, tmp);
            run_sentence(int'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), ra, oa, rb, ob, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
